// File: rtl/mfunc_reg_pkg.sv
// Shared definitions for the register master: FSM encoding, field widths
// and a helper that extracts the sub-block select from a host address.
package mfunc_reg_pkg;

  localparam int ADDR_W     = 16;
  localparam int SUB_ADDR_W = 12;
  localparam int DATA_W     = 32;
  localparam int SEL_W      = 4;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Upper nibble of the host address picks the sub-block.
  function automatic logic [SEL_W-1:0] addr_sel(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:ADDR_W-SEL_W];
  endfunction

endpackage

// File: rtl/mfunc_rd_mux.sv
// Combinational read-slice selector: picks the 32-bit slice of the
// concatenated sub-block read bus addressed by i_sel, and flags selects
// that point past the last attached sub-block (data is then 0).
module mfunc_rd_mux
  import mfunc_reg_pkg::*;
#(
  parameter int NUM_SUB = 4
) (
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [NUM_SUB*DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_out_of_range
);

  // Scan every attached slice; a hit replaces the zero default and clears the flag.
  always_comb begin
    o_rd_data      = {DATA_W{1'b0}};
    o_out_of_range = 1'b1;
    for (int n = 0; n < NUM_SUB; n++) begin
      o_rd_data      = (i_sel == SEL_W'(n)) ? i_rd_data[n*DATA_W +: DATA_W] : o_rd_data;
      o_out_of_range = (i_sel == SEL_W'(n)) ? 1'b0 : o_out_of_range;
    end
  end

endmodule

// File: rtl/mfunc_reg_master.sv
// Host-to-register-bus master. One command at a time flows through
// IDLE (accept) -> ACCESS (one-cycle strobe / read sample) -> RESP
// (response held until the host takes it). All outputs except cmd_ready
// are registered; cmd_ready is a pure decode of the state register.
module mfunc_reg_master
  import mfunc_reg_pkg::*;
#(
  parameter int NUM_SUB = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SUB-1:0]        reg_wr_en,
  output logic [SUB_ADDR_W-1:0]     sub_reg_addr,
  output logic [DATA_W-1:0]         reg_wr_data,
  input  logic [NUM_SUB*DATA_W-1:0] reg_rd_data,
  output logic [CNT_W-1:0]          txn_cnt
);

  state_t                r_state;
  logic                  r_write;
  logic [SEL_W-1:0]      r_sel;
  logic [NUM_SUB-1:0]    r_wr_en;
  logic [SUB_ADDR_W-1:0] r_sub_reg_addr;
  logic [DATA_W-1:0]     r_reg_wr_data;
  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_err;
  logic [CNT_W-1:0]      r_txn_cnt;

  logic [NUM_SUB-1:0]    w_wr_en_next;
  logic [DATA_W-1:0]     w_mux_data;
  logic                  w_mux_oor;

  // Strobe pattern for an incoming command; an unmapped select matches no bit.
  always_comb begin
    w_wr_en_next = {NUM_SUB{1'b0}};
    for (int n = 0; n < NUM_SUB; n++) begin
      w_wr_en_next[n] = cmd_write && (addr_sel(cmd_addr) == SEL_W'(n));
    end
  end

  mfunc_rd_mux #(
    .NUM_SUB (NUM_SUB)
  ) u_rd_mux (
    .i_sel          (r_sel),
    .i_rd_data      (reg_rd_data),
    .o_rd_data      (w_mux_data),
    .o_out_of_range (w_mux_oor)
  );

  // Transaction FSM; strobe/address/data are loaded at acceptance so they are
  // valid throughout ACCESS, and hold their values afterwards (strobe excepted).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_write        <= 1'b0;
      r_sel          <= {SEL_W{1'b0}};
      r_wr_en        <= {NUM_SUB{1'b0}};
      r_sub_reg_addr <= {SUB_ADDR_W{1'b0}};
      r_reg_wr_data  <= {DATA_W{1'b0}};
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= {DATA_W{1'b0}};
      r_rsp_err      <= 1'b0;
      r_txn_cnt      <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_state        <= ST_ACCESS;
            r_write        <= cmd_write;
            r_sel          <= addr_sel(cmd_addr);
            r_wr_en        <= w_wr_en_next;
            r_sub_reg_addr <= cmd_addr[SUB_ADDR_W-1:0];
            r_reg_wr_data  <= cmd_wdata;
          end
        end
        ST_ACCESS: begin
          r_state     <= ST_RESP;
          r_wr_en     <= {NUM_SUB{1'b0}};
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= w_mux_oor;
          r_rsp_rdata <= (!r_write && !w_mux_oor) ? w_mux_data : {DATA_W{1'b0}};
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_txn_cnt   <= r_txn_cnt + 16'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_wr_en     <= {NUM_SUB{1'b0}};
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = (r_state == ST_IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign reg_wr_en    = r_wr_en;
  assign sub_reg_addr = r_sub_reg_addr;
  assign reg_wr_data  = r_reg_wr_data;
  assign txn_cnt      = r_txn_cnt;

endmodule
